// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      int unsigned v;
      r = 0;
      v = (value > 0) ? value - 1 : 0;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/seq_mult_pipe_if.sv
// Operand and result valid/ready handshakes of seq_mult_pipe.
interface seq_mult_pipe_if #(
   parameter int WIDTH = seq_mult_pkg::DEFAULT_WIDTH
);
   logic               In_Valid;
   logic               In_Ready;
   logic               Signed_Mode;
   logic [WIDTH-1:0]   A;
   logic [WIDTH-1:0]   B;
   logic               Out_Valid;
   logic               Out_Ready;
   logic [WIDTH-1:0]   Out_A;
   logic [WIDTH-1:0]   Out_B;
   logic [2*WIDTH-1:0] P;

   modport master (
      output In_Valid, Signed_Mode, A, B, Out_Ready,
      input  In_Ready, Out_Valid, Out_A, Out_B, P
   );

   modport slave (
      input  In_Valid, Signed_Mode, A, B, Out_Ready,
      output In_Ready, Out_Valid, Out_A, Out_B, P
   );
endinterface

// File: rtl/seq_mult_core.sv
// Unsigned shift-add datapath: accumulator, multiplicand register and iteration counter.
module seq_mult_core
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               Clk,
   input  logic               Rst_n,
   input  logic               start,
   input  logic               run,
   input  logic [WIDTH-1:0]   mcand_in,
   input  logic [WIDTH-1:0]   mplier_in,
   output logic               last,
   output logic [2*WIDTH-1:0] prod
);
   localparam int unsigned CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   addend;
   logic [WIDTH:0]     upper;
   logic [CW-1:0]      cnt;

   // The 2*WIDTH+1-bit sum {upper, acc[WIDTH-1:0]} is never stored: its LSB
   // is shifted out in the same cycle, so only 2*WIDTH bits are registered.
   always_comb begin
      addend  = acc[0] ? mcand : '0;
      upper   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
      acc_nxt = {upper, acc[WIDTH-1:1]};
      last    = run && (cnt == CW'(WIDTH - 1));
      prod    = acc_nxt;
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         acc   <= '0;
         mcand <= '0;
         cnt   <= '0;
      end else if (start) begin
         acc   <= {{WIDTH{1'b0}}, mplier_in};
         mcand <= mcand_in;
         cnt   <= '0;
      end else if (run) begin
         acc   <= acc_nxt;
         cnt   <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/seq_mult_pipe.sv
// Signed/unsigned sequential multiplier with valid/ready operand and result handshakes.
module seq_mult_pipe
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input logic            Clk,
   input logic            Rst_n,
   seq_mult_pipe_if.slave bus
);
   state_t             state;
   logic               in_ready_q;
   logic               out_valid_q;
   logic               neg;
   logic [WIDTH-1:0]   out_a_q;
   logic [WIDTH-1:0]   out_b_q;
   logic [2*WIDTH-1:0] p_q;

   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic               core_start;
   logic               core_run;
   logic               core_last;
   logic [2*WIDTH-1:0] core_prod;

   // Negating -2^(WIDTH-1) wraps to itself, which read as unsigned is the
   // correct magnitude 2^(WIDTH-1).
   always_comb begin
      mag_a      = (bus.Signed_Mode && bus.A[WIDTH-1]) ? -bus.A : bus.A;
      mag_b      = (bus.Signed_Mode && bus.B[WIDTH-1]) ? -bus.B : bus.B;
      core_start = (state == IDLE) && bus.In_Valid && in_ready_q;
      core_run   = (state == BUSY);
   end

   seq_mult_core #(.WIDTH(WIDTH)) u_core (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .start     (core_start),
      .run       (core_run),
      .mcand_in  (mag_a),
      .mplier_in (mag_b),
      .last      (core_last),
      .prod      (core_prod)
   );

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state       <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         neg         <= 1'b0;
         out_a_q     <= '0;
         out_b_q     <= '0;
         p_q         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.In_Valid && in_ready_q) begin
                  state      <= BUSY;
                  in_ready_q <= 1'b0;
                  out_a_q    <= bus.A;
                  out_b_q    <= bus.B;
                  neg        <= bus.Signed_Mode & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
               end
            end
            BUSY: begin
               if (core_last) begin
                  state       <= DONE;
                  out_valid_q <= 1'b1;
                  p_q         <= neg ? -core_prod : core_prod;
               end
            end
            DONE: begin
               if (bus.Out_Ready) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.In_Ready  = in_ready_q;
   assign bus.Out_Valid = out_valid_q;
   assign bus.Out_A     = out_a_q;
   assign bus.Out_B     = out_b_q;
   assign bus.P         = p_q;

endmodule

// File: tb/tb_seq_mult_pipe.sv
// Bench for seq_mult_pipe at WIDTH 8, 2 and 16 against an integer-arithmetic product model.
module tb_seq_mult_pipe;
   localparam int NI = 3;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic        iv   [NI];
   logic        sm   [NI];
   logic        ordy [NI];
   logic [31:0] av   [NI];
   logic [31:0] bv   [NI];
   logic        ir   [NI];
   logic        ov   [NI];
   logic [63:0] pv   [NI];
   logic [31:0] oa   [NI];
   logic [31:0] ob   [NI];

   seq_mult_pipe_if #(.WIDTH(8))  b8  ();
   seq_mult_pipe_if #(.WIDTH(2))  b2  ();
   seq_mult_pipe_if #(.WIDTH(16)) b16 ();

   seq_mult_pipe #(.WIDTH(8))  u8  (.Clk(clk), .Rst_n(rst_n), .bus(b8));
   seq_mult_pipe #(.WIDTH(2))  u2  (.Clk(clk), .Rst_n(rst_n), .bus(b2));
   seq_mult_pipe #(.WIDTH(16)) u16 (.Clk(clk), .Rst_n(rst_n), .bus(b16));

   assign b8.In_Valid    = iv[0];
   assign b8.Signed_Mode = sm[0];
   assign b8.A           = av[0][7:0];
   assign b8.B           = bv[0][7:0];
   assign b8.Out_Ready   = ordy[0];
   assign ir[0] = b8.In_Ready;
   assign ov[0] = b8.Out_Valid;
   assign pv[0] = {48'b0, b8.P};
   assign oa[0] = {24'b0, b8.Out_A};
   assign ob[0] = {24'b0, b8.Out_B};

   assign b2.In_Valid    = iv[1];
   assign b2.Signed_Mode = sm[1];
   assign b2.A           = av[1][1:0];
   assign b2.B           = bv[1][1:0];
   assign b2.Out_Ready   = ordy[1];
   assign ir[1] = b2.In_Ready;
   assign ov[1] = b2.Out_Valid;
   assign pv[1] = {60'b0, b2.P};
   assign oa[1] = {30'b0, b2.Out_A};
   assign ob[1] = {30'b0, b2.Out_B};

   assign b16.In_Valid    = iv[2];
   assign b16.Signed_Mode = sm[2];
   assign b16.A           = av[2][15:0];
   assign b16.B           = bv[2][15:0];
   assign b16.Out_Ready   = ordy[2];
   assign ir[2] = b16.In_Ready;
   assign ov[2] = b16.Out_Valid;
   assign pv[2] = {32'b0, b16.P};
   assign oa[2] = {16'b0, b16.Out_A};
   assign ob[2] = {16'b0, b16.Out_B};

   function automatic int wd(input int i);
      case (i)
         0:       return 8;
         1:       return 2;
         default: return 16;
      endcase
   endfunction

   function automatic logic [31:0] mask(input int w);
      return 32'((longint'(1) << w) - 1);
   endfunction

   // Product as plain integers: interpret operands, multiply, keep 2*w bits.
   function automatic logic [63:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                         input logic s);
      longint x, y, p;
      x = longint'(a & mask(w));
      y = longint'(b & mask(w));
      if (s && a[w-1]) x = x - (longint'(1) << w);
      if (s && b[w-1]) y = y - (longint'(1) << w);
      p = x * y;
      return 64'(p) & ((64'(1) << (2 * w)) - 64'(1));
   endfunction

   task automatic wait_ready(input int i);
      int n = 0;
      while (!ir[i] && n < 64) begin
         @(posedge clk); #1;
         n++;
      end
      if (!ir[i]) begin
         checks++; errors++;
         $display("FAIL ready_timeout inst=%0d In_Ready=%0b required 1", i, ir[i]);
      end
   endtask

   task automatic start(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
      wait_ready(i);
      av[i] = a; bv[i] = b; sm[i] = s; iv[i] = 1'b1;
      @(posedge clk); #1;
      iv[i] = 1'b0;
      av[i] = $urandom; bv[i] = $urandom; sm[i] = 1'($urandom);
   endtask

   task automatic wait_valid(input int i, output int lat);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!ov[i] && lat < 100);
   endtask

   task automatic test_reset();
      for (int i = 0; i < NI; i++) begin
         iv[i] = 0; sm[i] = 0; ordy[i] = 1; av[i] = 0; bv[i] = 0;
      end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (ir[i] !== 1'b1 || ov[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags inst=%0d In_Ready=%0b Out_Valid=%0b required 1/0", i, ir[i], ov[i]);
         end
         checks++;
         if (pv[i] !== 64'd0 || oa[i] !== 32'd0 || ob[i] !== 32'd0) begin
            errors++;
            $display("FAIL reset_data inst=%0d P=%0h Out_A=%0h Out_B=%0h required 0", i, pv[i], oa[i], ob[i]);
         end
      end
   endtask

   typedef struct {
      int          i;
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [63:0] p;
   } vec_t;

   task automatic test_directed();
      vec_t tv [11];
      int   lat;
      tv[0]  = '{0, 32'h03,   32'h05,   1'b0, 64'h0000_000F};
      tv[1]  = '{0, 32'hFF,   32'hFF,   1'b0, 64'h0000_FE01};
      tv[2]  = '{0, 32'hFD,   32'h05,   1'b1, 64'h0000_FFF1};
      tv[3]  = '{0, 32'h80,   32'h80,   1'b1, 64'h0000_4000};
      tv[4]  = '{0, 32'h00,   32'h80,   1'b1, 64'h0000_0000};
      tv[5]  = '{0, 32'h80,   32'h01,   1'b1, 64'h0000_FF80};
      tv[6]  = '{1, 32'h2,    32'h2,    1'b1, 64'h4};
      tv[7]  = '{1, 32'h3,    32'h3,    1'b0, 64'h9};
      tv[8]  = '{1, 32'h3,    32'h2,    1'b1, 64'h2};
      tv[9]  = '{2, 32'hFFFF, 32'hFFFF, 1'b0, 64'hFFFE_0001};
      tv[10] = '{2, 32'h8000, 32'h8000, 1'b1, 64'h4000_0000};
      foreach (tv[k]) begin
         start(tv[k].i, tv[k].a, tv[k].b, tv[k].s);
         wait_valid(tv[k].i, lat);
         checks++;
         if (lat !== wd(tv[k].i)) begin
            errors++;
            $display("FAIL dir_latency vec=%0d latency=%0d required %0d", k, lat, wd(tv[k].i));
         end
         checks++;
         if (pv[tv[k].i] !== tv[k].p || oa[tv[k].i] !== tv[k].a || ob[tv[k].i] !== tv[k].b) begin
            errors++;
            $display("FAIL dir_result vec=%0d P=%0h A=%0h B=%0h required %0h %0h %0h",
                     k, pv[tv[k].i], oa[tv[k].i], ob[tv[k].i], tv[k].p, tv[k].a, tv[k].b);
         end
         @(posedge clk); #1;
         checks++;
         if (ov[tv[k].i] !== 1'b0 || ir[tv[k].i] !== 1'b1) begin
            errors++;
            $display("FAIL dir_handshake vec=%0d Out_Valid=%0b In_Ready=%0b required 0/1",
                     k, ov[tv[k].i], ir[tv[k].i]);
         end
      end
   endtask

   task automatic test_random();
      int          i, w, lat;
      logic [31:0] a, b;
      logic        s;
      logic [63:0] exp_p;
      for (int n = 0; n < 60; n++) begin
         i = $urandom_range(0, NI - 1);
         w = wd(i);
         a = $urandom & mask(w);
         b = $urandom & mask(w);
         s = 1'($urandom);
         exp_p = model(w, a, b, s);
         start(i, a, b, s);
         wait_valid(i, lat);
         checks++;
         if (lat !== w || pv[i] !== exp_p || oa[i] !== a || ob[i] !== b) begin
            errors++;
            $display("FAIL rand_result w=%0d a=%0h b=%0h s=%0b latency=%0d P=%0h A=%0h B=%0h required %0d %0h",
                     w, a, b, s, lat, pv[i], oa[i], ob[i], w, exp_p);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure();
      int          lat;
      logic [31:0] a, b;
      logic [63:0] exp_p;
      a = $urandom & mask(8);
      b = $urandom & mask(8);
      exp_p = model(8, a, b, 1'b1);
      ordy[0] = 1'b0;
      start(0, a, b, 1'b1);
      wait_valid(0, lat);
      checks++;
      if (pv[0] !== exp_p) begin
         errors++;
         $display("FAIL bp_result P=%0h required %0h", pv[0], exp_p);
      end
      for (int n = 0; n < 20; n++) begin
         iv[0] = 1'b1; av[0] = $urandom; bv[0] = $urandom; sm[0] = 1'($urandom);
         @(posedge clk); #1;
         checks++;
         if (pv[0] !== exp_p || oa[0] !== a || ob[0] !== b || ir[0] !== 1'b0 || ov[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold cycle=%0d P=%0h A=%0h B=%0h In_Ready=%0b Out_Valid=%0b required %0h %0h %0h 0 1",
                     n, pv[0], oa[0], ob[0], ir[0], ov[0], exp_p, a, b);
         end
      end
      iv[0] = 1'b0;
      ordy[0] = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
         errors++;
         $display("FAIL bp_release Out_Valid=%0b In_Ready=%0b required 0/1", ov[0], ir[0]);
      end
   endtask

   task automatic test_back_to_back();
      int          lat, c, prev;
      logic [31:0] a, b;
      logic        s;
      logic [63:0] exp_p;
      prev = 0;
      iv[0] = 1'b1;
      for (int n = 0; n < 5; n++) begin
         wait_ready(0);
         a = $urandom & mask(8); b = $urandom & mask(8); s = 1'($urandom);
         exp_p = model(8, a, b, s);
         av[0] = a; bv[0] = b; sm[0] = s;
         @(posedge clk); #1;
         c = cyc;
         av[0] = $urandom; bv[0] = $urandom;
         if (n > 0) begin
            checks++;
            if (c - prev !== 10) begin
               errors++;
               $display("FAIL b2b_interval n=%0d interval=%0d required 10", n, c - prev);
            end
         end
         prev = c;
         wait_valid(0, lat);
         checks++;
         if (lat !== 8 || pv[0] !== exp_p) begin
            errors++;
            $display("FAIL b2b_result n=%0d latency=%0d P=%0h required 8 %0h", n, lat, pv[0], exp_p);
         end
         @(posedge clk); #1;
      end
      iv[0] = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int seen, lat;
      start(0, 32'd7, 32'd9, 1'b0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      checks++;
      if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || pv[0] !== 64'd0 || oa[0] !== 32'd0 || ob[0] !== 32'd0) begin
         errors++;
         $display("FAIL midrst_state Out_Valid=%0b In_Ready=%0b P=%0h A=%0h B=%0h required 0 1 0 0 0",
                  ov[0], ir[0], pv[0], oa[0], ob[0]);
      end
      seen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (ov[0]) seen = 1;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL midrst_no_valid seen=%0d required 0", seen);
      end
      start(0, 32'd2, 32'd2, 1'b0);
      wait_valid(0, lat);
      checks++;
      if (lat !== 8 || pv[0] !== 64'd4) begin
         errors++;
         $display("FAIL midrst_after latency=%0d P=%0h required 8 4", lat, pv[0]);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_mult_pipe.md
# seq_mult_pipe

Parametrised sequential shift-add multiplier that replaces the fixed 2x2 registered multiplier in the lab datapath. It accepts a pair of WIDTH-bit operands over a valid/ready handshake and computes their signed or unsigned product in WIDTH iterations. It returns the 2*WIDTH-bit product together with registered copies of the operands over a second valid/ready handshake. It sits between the operand source (switches, or a bench driver) and the display/result consumer.

## Interface
- WIDTH, 8: operand width in bits (2..32); product is 2*WIDTH bits.
- Clk  input  1  rising-edge clock. One clock domain.
- Rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of Clk.
- In_Valid  input  1  operand pair A/B/Signed_Mode is valid.
- In_Ready  output  1  block can accept an operand pair.
- Signed_Mode  input  1  1 means A and B are two's complement; 0 means unsigned. Sampled at accept.
- A  input  WIDTH  multiplicand.
- B  input  WIDTH  multiplier.
- Out_Valid  output  1  P/Out_A/Out_B hold a valid result.
- Out_Ready  input  1  consumer accepts the result.
- Out_A  output  WIDTH  A as captured at accept.
- Out_B  output  WIDTH  B as captured at accept.
- P  output  2*WIDTH  product.

## Operation
- States:
  - IDLE: In_Ready=1. An accept happens on an edge with In_Valid&&In_Ready.
  - BUSY: WIDTH iterations.
  - DONE: Out_Valid=1.
- Transitions:
  - IDLE->BUSY on accept.
  - BUSY->DONE when the iteration counter reaches WIDTH-1.
  - DONE->IDLE on Out_Valid&&Out_Ready.
  - Otherwise the state holds.
- At accept:
  - Capture A and B into Out_A and Out_B.
  - Latch Signed_Mode.
  - Form magnitudes: if Signed_Mode, |A| and |B| as WIDTH-bit unsigned values; otherwise A and B unchanged.
  - Latch neg = Signed_Mode & (A[MSB]^B[MSB]).
  - Clear the accumulator and the counter.
- Each BUSY cycle:
  - If the multiplier LSB is 1, add the multiplicand to the upper half of the 2*WIDTH+1-bit accumulator.
  - Shift the accumulator right by 1.
  - Increment the counter.
- Entering DONE: P = neg ? -acc : acc, truncated to 2*WIDTH bits.
- Most-negative operand: the magnitude of -2^(WIDTH-1) is exactly 2^(WIDTH-1) and fits in WIDTH bits unsigned. It must not overflow.
  - -2^(W-1) * -2^(W-1) = +2^(2W-2).
- Zero product: P=0 regardless of neg, with no -0 artefact.
- While BUSY or DONE, In_Ready=0 and In_Valid/A/B/Signed_Mode changes are ignored.
- In DONE, P/Out_A/Out_B are held stable until the output handshake completes. Out_Ready may be held low indefinitely.

## Timing
- Reset (Rst_n=0 at an edge):
  - state=IDLE, In_Ready=1, Out_Valid=0.
  - P=0, Out_A=0, Out_B=0, counter=0.
- Reset has priority over every other event, including mid-BUSY and mid-DONE. The in-flight result is discarded and no Out_Valid is produced.
- Latency: accept on edge k. Out_Valid rises after edge k+WIDTH, so it is observable in cycle k+WIDTH.
- If Out_Ready=1 when Out_Valid rises, the handshake completes on edge k+WIDTH+1. In_Ready is 1 after that edge.
- Minimum initiation interval: WIDTH+2 cycles. No overlap of operations.
- In_Ready and Out_Valid are registered outputs, with no combinational path from inputs.
- Out_Valid and In_Ready are never both 1.

## Structure
- Shared package seq_mult_pkg:
  - state enum (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
  - DEFAULT_WIDTH=8.
  - Counter width function clog2(WIDTH).
- Natural sub-module: seq_mult_core, holding the accumulator, shift-add datapath and counter, with a start/done interface.
- The top level holds the FSM, the handshakes, the sign handling and the operand/result registers.

## Test plan
Default WIDTH=8 unless stated.
- Reset then idle: after reset -> In_Ready=1, Out_Valid=0, P=0, Out_A=0, Out_B=0.
- Unsigned basic: A=8'd3, B=8'd5, Signed_Mode=0 -> Out_Valid after 8 cycles, P=16'd15, Out_A=3, Out_B=5.
- Unsigned max: A=B=8'hFF, Signed_Mode=0 -> P=16'hFE01.
- Signed cases, Signed_Mode=1:
  - A=8'hFD (-3), B=8'h05 -> P=16'hFFF1.
  - A=B=8'h80 -> P=16'h4000.
  - A=8'h00, B=8'h80 -> P=16'h0000.
- Backpressure: Out_Ready=0 for 20 cycles after Out_Valid, with A/B toggling on the inputs -> P/Out_A/Out_B stable, In_Ready=0. Raising Out_Ready completes the handshake in one edge, and In_Ready=1 in the next cycle.
- Reset mid-operation: accept A=7, B=9, then drive Rst_n=0 at cycle 4 of BUSY -> no Out_Valid, all outputs 0, In_Ready=1. A following 2*2 yields P=4.
- Width sweep: repeat the unsigned and signed-most-negative cases for WIDTH=2 and WIDTH=16.
  - WIDTH=2: A=2'b10, B=2'b10 signed -> P=4'b0100, latency 2.
